// File: rtl/mult_rr_arbiter.sv
// Round-robin front end that time-shares one sequential multiplier among NUM_REQ
// requesters and returns each product tagged with the index of its requester.
module mult_rr_arbiter #(
    parameter int  NUM_REQ      = 4,
    parameter int  WIDTH        = 32,
    parameter int  MULT_LATENCY = 2,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]  req_x,
    input  logic [NUM_REQ*WIDTH-1:0]  req_y,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic signed [2*WIDTH-1:0] rsp_z,
    output logic [ID_W-1:0]           rsp_id,
    output logic signed [WIDTH-1:0]   mult_x,
    output logic signed [WIDTH-1:0]   mult_y,
    input  logic signed [2*WIDTH-1:0] mult_z,
    output logic                      busy
);
    localparam int              CNT_W  = $clog2(MULT_LATENCY + 1);
    localparam logic [ID_W:0]   C_NREQ = NUM_REQ[ID_W:0];
    localparam logic [ID_W-1:0] C_LAST = ID_W'(NUM_REQ - 1);

    // IDLE: arbitrate | BUSY: hold X/Y for MULT_LATENCY edges | RESP: wait for rsp_ready
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    state_t r_state, w_state_nxt;

    logic [ID_W-1:0]           r_rr_ptr;
    logic [ID_W-1:0]           r_id;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_rsp_valid;
    logic signed [2*WIDTH-1:0] r_rsp_z;
    logic [ID_W-1:0]           r_rsp_id;
    logic signed [WIDTH-1:0]   r_mult_x;
    logic signed [WIDTH-1:0]   r_mult_y;

    logic [2*NUM_REQ-1:0]      w_req_dbl;
    logic [NUM_REQ-1:0]        w_req_rot;
    logic                      w_any_req;
    logic [ID_W-1:0]           w_rot_off;
    logic [ID_W:0]             w_grant_sum;
    logic [ID_W-1:0]           w_grant_idx;
    logic                      w_accept;
    logic [ID_W-1:0]           w_id_inc;

    // Rotate requests so bit 0 is the requester at rr_ptr; lowest set bit wins.
    assign w_req_dbl = {req_valid, req_valid};
    assign w_req_rot = w_req_dbl[r_rr_ptr +: NUM_REQ];
    assign w_any_req = |req_valid;

    always_comb begin
        w_rot_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) w_rot_off = ID_W'(k);
        end
    end

    assign w_grant_sum = {1'b0, r_rr_ptr} + {1'b0, w_rot_off};
    assign w_grant_idx = (w_grant_sum >= C_NREQ) ? ID_W'(w_grant_sum - C_NREQ)
                                                 : w_grant_sum[ID_W-1:0];
    assign w_accept    = !rst && (r_state == ST_IDLE) && w_any_req;
    assign w_id_inc    = (r_id == C_LAST) ? '0 : r_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)              w_state_nxt = ST_BUSY;
            ST_BUSY: if (r_cnt == CNT_W'(1))    w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)             w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_z     <= '0;
            r_rsp_id    <= '0;
            r_mult_x    <= '0;
            r_mult_y    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mult_x <= req_x[int'(w_grant_idx)*WIDTH +: WIDTH];
                        r_mult_y <= req_y[int'(w_grant_idx)*WIDTH +: WIDTH];
                        r_id     <= w_grant_idx;
                        r_cnt    <= CNT_W'(MULT_LATENCY);
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_rsp_z     <= mult_z;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_id_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_z     = r_rsp_z;
    assign rsp_id    = r_rsp_id;
    assign mult_x    = r_mult_x;
    assign mult_y    = r_mult_y;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Bench for mult_rr_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of grants, latency and responses.
module tb_mult_rr_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int L   = 2;
    localparam int IDW = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N*W-1:0]        req_x;
    logic [N*W-1:0]        req_y;
    logic [N-1:0]          req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic signed [2*W-1:0] rsp_z;
    logic [IDW-1:0]        rsp_id;
    logic signed [W-1:0]   mult_x;
    logic signed [W-1:0]   mult_y;
    logic signed [2*W-1:0] mult_z;
    logic                  busy;

    always #5 clk = ~clk;

    mult_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MULT_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_id(rsp_id), .mult_x(mult_x), .mult_y(mult_y),
        .mult_z(mult_z), .busy(busy)
    );

    // Multiplier stand-in with L-1 register stages: Z is only correct L edges after X/Y load.
    logic signed [2*W-1:0] mz_q = '0;
    always @(posedge clk) mz_q <= mult_x * mult_y;
    assign mult_z = mz_q;

    int n_checks = 0;
    int n_err    = 0;

    int                    m_ptr;
    bit                    m_active;
    int                    m_age;
    int                    m_id;
    logic signed [W-1:0]   m_x, m_y;
    logic signed [2*W-1:0] m_z;
    bit                    m_after_rst;
    bit                    keep [N];
    int                    post_accept;

    int                    grant_log [$];
    logic signed [2*W-1:0] rsp_z_log [$];
    int                    rsp_id_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic signed [W-1:0] rand_op();
        if ($urandom_range(1) == 1) return W'($urandom);
        return W'($urandom_range(200)) - W'(100);
    endfunction

    task automatic set_req(input int i, input logic signed [W-1:0] x, input logic signed [W-1:0] y);
        req_valid[i]     = 1'b1;
        req_x[i*W +: W]  = x;
        req_y[i*W +: W]  = y;
    endtask

    // One cycle: check settled outputs, log handshakes, advance the model over the next edge.
    task automatic tick();
        int g;
        int dg;
        bit exp_rv;
        logic [N-1:0] exp_rdy;
        #1;
        g       = -1;
        exp_rdy = '0;
        exp_rv  = m_active && (m_age >= L);
        if (!rst && !m_active) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(m_active));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("rsp_z", rsp_z, m_z);
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
        end else if (m_after_rst) begin
            chk("rsp_z_rst", rsp_z, 64'd0);
            chk("rsp_id_rst", 64'(rsp_id), 64'd0);
        end
        if (m_active || m_after_rst) begin
            chk("mult_x", 64'(mult_x), 64'(m_x));
            chk("mult_y", 64'(mult_y), 64'(m_y));
        end
        if (rsp_valid && rsp_ready) begin
            rsp_z_log.push_back(rsp_z);
            rsp_id_log.push_back(int'(rsp_id));
        end
        dg = -1;
        for (int k = 0; k < N; k++) if (req_ready[k] && req_valid[k]) dg = k;
        if (dg >= 0) grant_log.push_back(dg);

        post_accept = -1;
        if (rst) begin
            m_active    = 1'b0;
            m_ptr       = 0;
            m_x         = '0;
            m_y         = '0;
            m_after_rst = 1'b1;
        end else if (!m_active) begin
            if (g >= 0) begin
                m_active    = 1'b1;
                m_age       = 0;
                m_id        = g;
                m_x         = req_x[g*W +: W];
                m_y         = req_y[g*W +: W];
                m_z         = m_x * m_y;
                m_after_rst = 1'b0;
                post_accept = g;
            end
        end else if (exp_rv && rsp_ready) begin
            m_active = 1'b0;
            m_ptr    = (m_id + 1) % N;
        end else begin
            m_age++;
        end
        @(negedge clk);
        if (post_accept >= 0 && !keep[post_accept]) req_valid[post_accept] = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input int idx, input logic signed [2*W-1:0] z, input int id);
        if (idx < rsp_z_log.size()) begin
            chk({tag, "_z"}, rsp_z_log[idx], z);
            chk({tag, "_id"}, 64'(rsp_id_log[idx]), 64'(id));
        end else begin
            chk({tag, "_present"}, 64'(rsp_z_log.size()), 64'(idx + 1));
        end
    endtask

    task automatic chk_grant(input string tag, input int idx, input int id);
        if (idx < grant_log.size()) chk(tag, 64'(grant_log[idx]), 64'(id));
        else                        chk({tag, "_present"}, 64'(grant_log.size()), 64'(idx + 1));
    endtask

    initial begin
        int rb;
        int gb;
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) keep[i] = 1'b0;
        repeat (2) @(negedge clk);
        m_active    = 1'b0;
        m_ptr       = 0;
        m_age       = 0;
        m_id        = 0;
        m_x         = '0;
        m_y         = '0;
        m_z         = '0;
        m_after_rst = 1'b1;
        rst         = 1'b0;

        // 1: single requester
        rb = rsp_z_log.size();
        gb = grant_log.size();
        set_req(0, 15, -31);
        repeat (6) tick();
        chk("t1_count", 64'(rsp_z_log.size() - rb), 64'd1);
        chk_grant("t1_grant", gb, 0);
        chk_rsp("t1", rb, -465, 0);

        // 2: all four at once from rr_ptr=0
        rst = 1'b1; tick(); rst = 1'b0;
        rb = rsp_z_log.size();
        set_req(0, 13, 29);
        set_req(1, -81, -55);
        set_req(2, -100, 6);
        set_req(3, 0, -300);
        repeat (20) tick();
        chk_rsp("t2_0", rb,     377,  0);
        chk_rsp("t2_1", rb + 1, 4455, 1);
        chk_rsp("t2_2", rb + 2, -600, 2);
        chk_rsp("t2_3", rb + 3, 0,    3);

        // 3: requesters 0 and 2 held continuously
        gb = grant_log.size();
        keep[0] = 1'b1;
        keep[2] = 1'b1;
        set_req(0, rand_op(), rand_op());
        set_req(2, rand_op(), rand_op());
        repeat (14) tick();
        keep[0] = 1'b0;
        keep[2] = 1'b0;
        req_valid = '0;
        repeat (6) tick();
        chk_grant("t3_g0", gb,     0);
        chk_grant("t3_g1", gb + 1, 2);
        chk_grant("t3_g2", gb + 2, 0);
        chk_grant("t3_g3", gb + 3, 2);

        // 4: consumer stalls for 5 cycles in RESP (rr_ptr=3 here)
        rb = rsp_z_log.size();
        rsp_ready = 1'b0;
        set_req(1, 7, 9);
        set_req(3, 5, -6);
        repeat (8) tick();
        chk("t4_stalled", 64'(rsp_z_log.size() - rb), 64'd0);
        rsp_ready = 1'b1;
        tick();
        chk("t4_one_hs", 64'(rsp_z_log.size() - rb), 64'd1);
        repeat (6) tick();
        chk_rsp("t4_a", rb,     -30, 3);
        chk_rsp("t4_b", rb + 1, 63,  1);

        // 5: reset while BUSY abandons the product
        rb = rsp_z_log.size();
        set_req(0, -12340, -54321);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = '0;
        gb = grant_log.size();
        set_req(1, rand_op(), rand_op());
        set_req(3, rand_op(), rand_op());
        repeat (12) tick();
        chk("t5_count", 64'(rsp_z_log.size() - rb), 64'd2);
        chk_grant("t5_first", gb, 1);
        chk_grant("t5_second", gb + 1, 3);

        // 6: rr_ptr wraps after requester 3
        set_req(3, rand_op(), rand_op());
        repeat (5) tick();
        rb = rsp_z_log.size();
        set_req(0, 1577, -40);
        repeat (5) tick();
        chk_rsp("t6", rb, -63080, 0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(2) == 0) set_req(i, rand_op(), rand_op());
                end else if ($urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            rst       = ($urandom_range(150) == 0);
            tick();
        end
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
